block_datapath: RTL and testbench
=================================

BLOCK_DATAPATH -- requirements
Module: block_datapath

Interface
REQ-001 Parameter X_MAX, default 160, meaning screen width in pixels.
REQ-002 Parameter Y_START, default 116, meaning initial top-left row; it SHALL be a multiple of BLOCK_H.
REQ-003 Parameter BLOCK_W, default 8, meaning block width in pixels (2..16).
REQ-004 Parameter BLOCK_H, default 4, meaning block height in pixels (1..16).
REQ-005 Parameter SPEED, default 1, meaning horizontal step per update, in pixels.
REQ-006 Parameter DELAY, default 12500000, meaning delay-counter length in cycles (at least 2).
REQ-007 clk  in  1  single system clock; all state updates on rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 reset_counter  in  1  active-low synchronous clear of the delay counter.
REQ-010 enable_counter  in  1  delay-counter increment enable.
REQ-011 reset_load  in  1  active-low synchronous clear of position, direction, pixel counter and flags.
REQ-012 ld_x, ld_y  in  1 each  position-update strobes.
REQ-013 count_x_enable  in  1  pixel-counter advance enable.
REQ-014 writeEn  in  1  write request from the control FSM.
REQ-015 colour_erase_enable  in  1  selects erase (black) colour.
REQ-016 stop_true  in  1  player stop request, as a level.
REQ-017 colour_in  in  3  block colour.
REQ-018 x_out  out  8  pixel column.
REQ-019 y_out  out  7  pixel row.
REQ-020 colour_out  out  3  pixel colour.
REQ-021 plot  out  1  pixel write strobe to the VGA adapter.
REQ-022 done_plot  out  1  last pixel of block being issued.
REQ-023 enable_erase  out  1  delay expired.
REQ-024 game_over  out  1  stack reached row 0.

Function
REQ-025 Registers: x_pos (8b), y_pos (7b), dir (1 = right), px/py pixel counters, cnt delay counter (ceil(log2 DELAY) bits), stop_flag, game_over.
REQ-026 x_out SHALL be x_pos+px and y_out SHALL be y_pos+py, combinational from registers only, valid in the same cycle as count_x_enable.
REQ-027 colour_out SHALL be 3'b000 when colour_erase_enable=1, else colour_in.
REQ-028 plot SHALL equal writeEn & ~game_over, combinational.
REQ-029 Pixel scan on count_x_enable=1: px increments; at px=BLOCK_W-1, px wraps to 0 and py increments; at py=BLOCK_H-1 with px=BLOCK_W-1, both wrap to 0.
REQ-030 done_plot SHALL be combinational count_x_enable & (px=BLOCK_W-1) & (py=BLOCK_H-1), high for exactly that one cycle.
REQ-031 px/py SHALL hold when count_x_enable=0.
REQ-032 Delay counter: reset_counter=0 clears cnt (priority over enable); enable_counter=1 increments cnt.
REQ-033 enable_erase SHALL be enable_counter & (cnt=DELAY-1); cnt SHALL wrap to 0 in that cycle.
REQ-034 stop_flag SHALL set on the clock where enable_erase=1 and stop_true=1, and SHALL clear on any ld_y=1 clock.
REQ-035 ld_x=1 with stop_flag=0, dir=1: if x_pos+BLOCK_W+SPEED <= X_MAX then x_pos += SPEED, else dir <= 0 and x_pos -= SPEED.
REQ-036 ld_x=1 with stop_flag=0, dir=0: if x_pos >= SPEED then x_pos -= SPEED, else dir <= 1 and x_pos += SPEED.
REQ-037 ld_y=1 with stop_flag=1: if y_pos >= BLOCK_H then y_pos -= BLOCK_H, x_pos <= 0 and dir <= 1; else game_over <= 1 and position holds. Any ld_x move is suppressed that clock.
REQ-038 While game_over=1, ld_x and ld_y SHALL be ignored; pixel scan and delay counter continue.
REQ-039 Simultaneous reset_load=0 with any strobe: reset_load wins.

Reset
REQ-040 resetn=0 SHALL asynchronously force x_pos=0, y_pos=Y_START, dir=1, px=py=0, cnt=0, stop_flag=0 and game_over=0.
REQ-041 reset_load=0 SHALL apply the same values as REQ-040 synchronously, except cnt.
REQ-042 Reset mid-scan SHALL abandon the scan; the next scan starts at px=py=0.
REQ-043 The first edge after resetn deasserts SHALL be a normal functional edge.

Verification
REQ-044 Defaults, count_x_enable held for 32 cycles -> x_out 0..7 repeating over y_out 116..119; done_plot high only on cycle 32; px/py=0 after.
REQ-045 DELAY=4, reset_counter pulsed then enable_counter held -> enable_erase high on every 4th enabled cycle; a reset_counter=0 mid-count restarts the count.
REQ-046 x_pos=151, dir=1, ld_x pulse -> x_pos=152; next ld_x -> dir=0, x_pos=151.
REQ-047 stop_true=1 during enable_erase, then ld_x=ld_y=1 -> y_pos=112, x_pos=0, dir=1, stop_flag=0.
REQ-048 y_pos=0, stop_flag=1, ld_y -> game_over=1; plot=0 despite writeEn=1; reset_load=0 -> game_over=0, y_pos=116.
REQ-049 resetn asserted mid-scan at px=3 -> outputs and registers reach reset values with no clock edge; scan restarts at px=0.

Source files
------------

// File: rtl/block_datapath.sv
// Datapath for a sliding block: position/direction, block pixel scan, movement delay
// counter, stop/drop handling and game-over detection, feeding a VGA pixel writer.
module block_datapath #(
   parameter int X_MAX   = 160,
   parameter int Y_START = 116,
   parameter int BLOCK_W = 8,
   parameter int BLOCK_H = 4,
   parameter int SPEED   = 1,
   parameter int DELAY   = 12500000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       reset_counter,
   input  logic       enable_counter,
   input  logic       reset_load,
   input  logic       ld_x,
   input  logic       ld_y,
   input  logic       count_x_enable,
   input  logic       writeEn,
   input  logic       colour_erase_enable,
   input  logic       stop_true,
   input  logic [2:0] colour_in,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour_out,
   output logic       plot,
   output logic       done_plot,
   output logic       enable_erase,
   output logic       game_over
);

   localparam int CW = $clog2(DELAY);

   logic [7:0]    x_pos_q, x_pos_d;
   logic [6:0]    y_pos_q, y_pos_d;
   logic          dir_q, dir_d;
   logic [3:0]    px_q, px_d, py_q, py_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stop_flag_q, stop_flag_d;
   logic          game_over_q, game_over_d;
   logic          px_last, py_last, right_fits;

   always_comb begin
      px_last      = (px_q == 4'(BLOCK_W - 1));
      py_last      = (py_q == 4'(BLOCK_H - 1));
      done_plot    = count_x_enable & px_last & py_last;
      enable_erase = enable_counter & (cnt_q == CW'(DELAY - 1));
      right_fits   = ({2'b00, x_pos_q} + 10'(BLOCK_W + SPEED)) <= 10'(X_MAX);

      x_out      = x_pos_q + 8'(px_q);
      y_out      = y_pos_q + 7'(py_q);
      colour_out = colour_erase_enable ? 3'b000 : colour_in;
      plot       = writeEn & ~game_over_q;
      game_over  = game_over_q;
   end

   // Delay counter: its own clear takes priority over the increment
   always_comb begin
      cnt_d = cnt_q;
      if (!reset_counter)
         cnt_d = '0;
      else if (enable_counter)
         cnt_d = enable_erase ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      px_d = px_q;
      py_d = py_q;
      if (!reset_load) begin
         px_d = '0;
         py_d = '0;
      end else if (count_x_enable) begin
         if (px_last) begin
            px_d = '0;
            py_d = py_last ? '0 : py_q + 1'b1;
         end else begin
            px_d = px_q + 1'b1;
         end
      end
   end

   // A drop (ld_y with stop pending) pre-empts any horizontal move in the same clock
   always_comb begin
      x_pos_d     = x_pos_q;
      y_pos_d     = y_pos_q;
      dir_d       = dir_q;
      stop_flag_d = stop_flag_q;
      game_over_d = game_over_q;
      if (!reset_load) begin
         x_pos_d     = '0;
         y_pos_d     = 7'(Y_START);
         dir_d       = 1'b1;
         stop_flag_d = 1'b0;
         game_over_d = 1'b0;
      end else begin
         if (ld_y && !game_over_q)
            stop_flag_d = 1'b0;
         else if (enable_erase && stop_true)
            stop_flag_d = 1'b1;
         if (!game_over_q) begin
            if (ld_y && stop_flag_q) begin
               if (y_pos_q >= 7'(BLOCK_H)) begin
                  y_pos_d = y_pos_q - 7'(BLOCK_H);
                  x_pos_d = '0;
                  dir_d   = 1'b1;
               end else begin
                  game_over_d = 1'b1;
               end
            end else if (ld_x && !stop_flag_q) begin
               if (dir_q) begin
                  if (right_fits) begin
                     x_pos_d = x_pos_q + 8'(SPEED);
                  end else begin
                     dir_d   = 1'b0;
                     x_pos_d = x_pos_q - 8'(SPEED);
                  end
               end else begin
                  if (x_pos_q >= 8'(SPEED)) begin
                     x_pos_d = x_pos_q - 8'(SPEED);
                  end else begin
                     dir_d   = 1'b1;
                     x_pos_d = x_pos_q + 8'(SPEED);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_pos_q     <= '0;
         y_pos_q     <= 7'(Y_START);
         dir_q       <= 1'b1;
         px_q        <= '0;
         py_q        <= '0;
         cnt_q       <= '0;
         stop_flag_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         x_pos_q     <= x_pos_d;
         y_pos_q     <= y_pos_d;
         dir_q       <= dir_d;
         px_q        <= px_d;
         py_q        <= py_d;
         cnt_q       <= cnt_d;
         stop_flag_q <= stop_flag_d;
         game_over_q <= game_over_d;
      end
   end

endmodule

// File: tb/tb_block_datapath.sv
// Directed bench for block_datapath: vector table for colour/plot logic plus
// hand-written sequences for scan, delay counter, movement, drop and game over.
module tb_block_datapath;

   logic       clk = 1'b0;
   logic       resetn, reset_counter, enable_counter, reset_load;
   logic       ld_x, ld_y, count_x_enable, writeEn, colour_erase_enable, stop_true;
   logic [2:0] colour_in;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot, done_plot, enable_erase, game_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   block_datapath #(
      .X_MAX(160), .Y_START(116), .BLOCK_W(8), .BLOCK_H(4), .SPEED(1), .DELAY(4)
   ) dut (
      .clk(clk), .resetn(resetn), .reset_counter(reset_counter),
      .enable_counter(enable_counter), .reset_load(reset_load), .ld_x(ld_x), .ld_y(ld_y),
      .count_x_enable(count_x_enable), .writeEn(writeEn),
      .colour_erase_enable(colour_erase_enable), .stop_true(stop_true),
      .colour_in(colour_in), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
      .plot(plot), .done_plot(done_plot), .enable_erase(enable_erase), .game_over(game_over)
   );

   typedef struct {
      logic       erase;
      logic       wen;
      logic [2:0] cin;
      logic [2:0] exp_colour;
      logic       exp_plot;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Run the delay counter up to its terminal count and request a stop there
   task automatic arm_stop();
      reset_counter = 1'b0;
      tick();
      reset_counter  = 1'b1;
      enable_counter = 1'b1;
      repeat (3) tick();
      chk("stop_ee", enable_erase, 1);
      stop_true = 1'b1;
      tick();
      stop_true      = 1'b0;
      enable_counter = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 3'd5, 3'd5, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 3'd5, 3'd0, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 3'd3, 3'd3, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 3'd7, 3'd0, 1'b0};

      resetn = 1'b0; reset_counter = 1'b1; enable_counter = 1'b0; reset_load = 1'b1;
      ld_x = 1'b0; ld_y = 1'b0; count_x_enable = 1'b0; writeEn = 1'b1;
      colour_erase_enable = 1'b0; stop_true = 1'b0; colour_in = 3'd2;
      #12 resetn = 1'b1;
      tick();

      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 116);
      chk("rst_done", done_plot, 0);
      chk("rst_ee", enable_erase, 0);
      chk("rst_go", game_over, 0);
      chk("rst_plot", plot, 1);

      for (int i = 0; i < 4; i++) begin
         colour_erase_enable = vecs[i].erase;
         writeEn             = vecs[i].wen;
         colour_in           = vecs[i].cin;
         #1;
         chk("vec_colour", colour_out, vecs[i].exp_colour);
         chk("vec_plot", plot, vecs[i].exp_plot);
      end
      colour_erase_enable = 1'b0;
      writeEn = 1'b1;

      // Full 8x4 block scan
      count_x_enable = 1'b1;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk("scan_x", x_out, i % 8);
         chk("scan_y", y_out, 116 + i / 8);
         chk("scan_done", done_plot, (i == 31) ? 1 : 0);
         tick();
      end
      count_x_enable = 1'b0;
      #1;
      chk("scan_end_x", x_out, 0);
      chk("scan_end_y", y_out, 116);

      // Hold, then asynchronous reset mid-scan at px=3
      count_x_enable = 1'b1;
      repeat (3) tick();
      count_x_enable = 1'b0;
      repeat (2) tick();
      chk("hold_x", x_out, 3);
      #2 resetn = 1'b0;
      #1;
      chk("async_x", x_out, 0);
      chk("async_y", y_out, 116);
      resetn = 1'b1;
      count_x_enable = 1'b1;
      #1;
      chk("restart_x0", x_out, 0);
      tick();
      chk("restart_x1", x_out, 1);
      tick();
      count_x_enable = 1'b0;
      reset_load = 1'b0;
      tick();
      reset_load = 1'b1;
      chk("rload_scan_x", x_out, 0);

      // Delay counter, DELAY=4
      reset_counter = 1'b0;
      tick();
      reset_counter  = 1'b1;
      enable_counter = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("cnt_ee", enable_erase, (k % 4 == 3) ? 1 : 0);
         tick();
      end
      repeat (2) tick();
      reset_counter = 1'b0;
      tick();
      reset_counter = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("cnt_restart", enable_erase, 0);
         tick();
      end
      enable_counter = 1'b0;
      #1;
      chk("cnt_gated", enable_erase, 0);
      tick();
      enable_counter = 1'b1;
      #1;
      chk("cnt_resume", enable_erase, 1);
      tick();
      enable_counter = 1'b0;

      // Horizontal movement and bounce at both edges
      ld_x = 1'b1;
      repeat (151) tick();
      chk("mv_151", x_out, 151);
      tick();
      chk("mv_152", x_out, 152);
      tick();
      chk("mv_bounce_r", x_out, 151);
      tick();
      chk("mv_left", x_out, 150);
      repeat (150) tick();
      chk("mv_0", x_out, 0);
      tick();
      chk("mv_bounce_l", x_out, 1);
      tick();
      chk("mv_right", x_out, 2);
      ld_x = 1'b0;

      // Stop, suppressed move, then drop
      arm_stop();
      ld_x = 1'b1;
      tick();
      chk("stop_hold_x", x_out, 2);
      ld_y = 1'b1;
      tick();
      ld_y = 1'b0;
      chk("drop_y", y_out, 112);
      chk("drop_x", x_out, 0);
      tick();
      ld_x = 1'b0;
      chk("drop_dir_flag", x_out, 1);

      // Stack down to row 0, then game over
      for (int r = 0; r < 28; r++) begin
         arm_stop();
         ld_y = 1'b1;
         tick();
         ld_y = 1'b0;
      end
      chk("stack_y0", y_out, 0);
      chk("stack_x0", x_out, 0);
      chk("stack_go0", game_over, 0);
      arm_stop();
      ld_y = 1'b1;
      tick();
      ld_y = 1'b0;
      chk("go_set", game_over, 1);
      chk("go_y", y_out, 0);
      chk("go_plot", plot, 0);
      ld_x = 1'b1;
      tick();
      ld_x = 1'b0;
      chk("go_ignore_x", x_out, 0);
      count_x_enable = 1'b1;
      tick();
      count_x_enable = 1'b0;
      chk("go_scan", x_out, 1);

      // reset_load wins over a simultaneous strobe
      reset_load = 1'b0;
      ld_x = 1'b1;
      tick();
      reset_load = 1'b1;
      ld_x = 1'b0;
      chk("rl_go", game_over, 0);
      chk("rl_y", y_out, 116);
      chk("rl_x", x_out, 0);
      chk("rl_plot", plot, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
